// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata, if_err,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata, dm_err,
    output mem_addr, mem_wdata, mem_write,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata, if_err,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata, dm_err,
    input  mem_addr, mem_wdata, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares a single-port registered-read memory between the fetch port and the data port.
// One access at a time: IDLE -> ACCESS -> [RDWAIT] -> RESP -> IDLE, all outputs registered.
module mem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 257,
  parameter int FIXED_PRI = 0
) (
  input  logic clock,
  input  logic reset,
  mem_arbiter_if.slave bus,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state, state_n;
  logic              grant_dm, grant_dm_n;
  logic              we_q, we_n;
  logic              last_dm, last_dm_n;
  logic              busy_n;

  logic              if_ack_q, if_ack_n;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_n;
  logic              if_err_q, if_err_n;
  logic              dm_ack_q, dm_ack_n;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_n;
  logic              dm_err_q, dm_err_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
  logic              mem_write_q, mem_write_n;

  logic              pick_dm;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant_dm    <= 1'b0;
      we_q        <= 1'b0;
      last_dm     <= 1'b0;
      busy        <= 1'b0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dm_rdata_q  <= '0;
      dm_err_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
    end else begin
      state       <= state_n;
      grant_dm    <= grant_dm_n;
      we_q        <= we_n;
      last_dm     <= last_dm_n;
      busy        <= busy_n;
      if_ack_q    <= if_ack_n;
      if_rdata_q  <= if_rdata_n;
      if_err_q    <= if_err_n;
      dm_ack_q    <= dm_ack_n;
      dm_rdata_q  <= dm_rdata_n;
      dm_err_q    <= dm_err_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      mem_write_q <= mem_write_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_dm_n  = grant_dm;
    we_n        = we_q;
    last_dm_n   = last_dm;
    if_ack_n    = 1'b0;
    if_rdata_n  = if_rdata_q;
    if_err_n    = if_err_q;
    dm_ack_n    = 1'b0;
    dm_rdata_n  = dm_rdata_q;
    dm_err_n    = dm_err_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    mem_write_n = 1'b0;
    pick_dm     = 1'b0;
    sel_addr    = '0;
    sel_we      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          // Conflict goes to DM under fixed priority, else to whichever port did not win last.
          pick_dm    = bus.dm_req && (!bus.if_req || (FIXED_PRI != 0) || !last_dm);
          sel_addr   = pick_dm ? bus.dm_addr : bus.if_addr;
          sel_we     = pick_dm && bus.dm_we;
          grant_dm_n = pick_dm;
          last_dm_n  = pick_dm;
          we_n       = sel_we;
          if ({1'b0, sel_addr} < DEPTH_L) begin
            state_n     = ACCESS;
            mem_addr_n  = sel_addr;
            mem_wdata_n = sel_we ? bus.dm_wdata : '0;
            mem_write_n = sel_we;
          end else begin
            state_n = RESP;
            if (pick_dm) begin
              dm_ack_n   = 1'b1;
              dm_err_n   = 1'b1;
              dm_rdata_n = '0;
            end else begin
              if_ack_n   = 1'b1;
              if_err_n   = 1'b1;
              if_rdata_n = '0;
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_n    = RESP;
          dm_ack_n   = 1'b1;
          dm_err_n   = 1'b0;
          dm_rdata_n = '0;
        end else begin
          state_n = RDWAIT;
        end
      end
      RDWAIT: begin
        state_n = RESP;
        if (grant_dm) begin
          dm_ack_n   = 1'b1;
          dm_err_n   = 1'b0;
          dm_rdata_n = bus.mem_rdata;
        end else begin
          if_ack_n   = 1'b1;
          if_err_n   = 1'b0;
          if_rdata_n = bus.mem_rdata;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, reset abort, arbitration order under both priority
// modes, and random traffic checked against a shadow memory and a fairness bound.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load  = 1'b1;
  logic busy0, busy1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) b0 ();
  mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) b1 ();

  mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(257), .FIXED_PRI(0)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.slave), .busy(busy0));
  mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(257), .FIXED_PRI(1)) dut1 (
    .clock(clock), .reset(reset), .bus(b1.slave), .busy(busy1));

  // Registered-read memories, preloaded with word i = 4*i+1.
  logic [15:0] mem0 [512];
  logic [15:0] mem1 [512];
  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 512; i++) begin
        mem0[i] <= 16'(4*i+1);
        mem1[i] <= 16'(4*i+1);
      end
    end else begin
      if (b0.mem_write) mem0[b0.mem_addr[8:0]] <= b0.mem_wdata;
      if (b1.mem_write) mem1[b1.mem_addr[8:0]] <= b1.mem_wdata;
    end
    b0.mem_rdata <= mem0[b0.mem_addr[8:0]];
    b1.mem_rdata <= mem1[b1.mem_addr[8:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          dm;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          err;
    int          lat;
    int          writes;
  } vec_t;

  vec_t vecs [11];

  // Single transaction on dut0; lat counts cycles from the request cycle to the ack cycle.
  task automatic xact0(input bit dm, input bit we, input logic [15:0] addr, input logic [15:0] wd,
                       output logic [15:0] rd, output logic er, output int lat,
                       output int nwr, output int oth);
    @(posedge clock); #1;
    if (dm) begin
      b0.dm_req = 1'b1; b0.dm_we = we; b0.dm_addr = addr; b0.dm_wdata = wd;
    end else begin
      b0.if_req = 1'b1; b0.if_addr = addr;
    end
    lat = -1; nwr = 0; oth = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (b0.mem_write) nwr++;
      if (dm ? b0.if_ack : b0.dm_ack) oth++;
      if (dm ? b0.dm_ack : b0.if_ack) begin
        rd  = dm ? b0.dm_rdata : b0.if_rdata;
        er  = dm ? b0.dm_err : b0.if_err;
        lat = k;
        break;
      end
    end
    @(posedge clock); #1;
    b0.if_req = 1'b0; b0.dm_req = 1'b0;
  endtask

  logic [15:0] shadow [512];

  task automatic rnd_port(input bit dm);
    for (int t = 0; t < 40; t++) begin
      int          gap;
      int          others;
      bit          got;
      bit          we;
      logic [15:0] a;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      bit          exp_er;
      gap = $urandom_range(0, 3);
      a   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(257, 65535)) : 16'($urandom_range(0, 256));
      we  = dm && ($urandom_range(0, 1) == 1);
      wd  = 16'($urandom);
      repeat (gap) begin @(posedge clock); #1; end
      if (dm) begin
        b0.dm_req = 1'b1; b0.dm_we = we; b0.dm_addr = a; b0.dm_wdata = wd;
      end else begin
        b0.if_req = 1'b1; b0.if_addr = a;
      end
      others = 0; got = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clock);
        if (dm ? b0.dm_ack : b0.if_ack) begin
          exp_er = (a >= 16'd257);
          exp_rd = (exp_er || we) ? 16'h0 : shadow[a[8:0]];
          chk(dm ? "rnd_dm_rdata" : "rnd_if_rdata", dm ? b0.dm_rdata : b0.if_rdata, exp_rd);
          chk(dm ? "rnd_dm_err" : "rnd_if_err", dm ? b0.dm_err : b0.if_err, exp_er);
          if (!exp_er && we) shadow[a[8:0]] = wd;
          got = 1'b1;
          break;
        end else if (dm ? b0.if_ack : b0.dm_ack) begin
          others++;
        end
      end
      chk(dm ? "rnd_dm_done" : "rnd_if_done", got, 1);
      chk(dm ? "rnd_dm_wait" : "rnd_if_wait", 32'(others > 1), 0);
      @(posedge clock); #1;
      if (dm) b0.dm_req = 1'b0; else b0.if_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat, nwr, oth, n, nif, ndm_at_if;
    int          order [6];

    b0.if_req = 0; b0.if_addr = '0; b0.dm_req = 0; b0.dm_we = 0; b0.dm_addr = '0; b0.dm_wdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;

    vecs[0]  = '{dm:0, we:0, addr:16'd1,    wdata:16'h0,    rdata:16'd5,    err:0, lat:3, writes:0};
    vecs[1]  = '{dm:1, we:1, addr:16'd4,    wdata:16'hBEEF, rdata:16'h0,    err:0, lat:2, writes:1};
    vecs[2]  = '{dm:1, we:0, addr:16'd4,    wdata:16'h0,    rdata:16'hBEEF, err:0, lat:3, writes:0};
    vecs[3]  = '{dm:1, we:1, addr:16'd300,  wdata:16'h1111, rdata:16'h0,    err:1, lat:1, writes:0};
    vecs[4]  = '{dm:1, we:0, addr:16'd256,  wdata:16'h0,    rdata:16'h0401, err:0, lat:3, writes:0};
    vecs[5]  = '{dm:0, we:0, addr:16'd257,  wdata:16'h0,    rdata:16'h0,    err:1, lat:1, writes:0};
    vecs[6]  = '{dm:0, we:0, addr:16'd4,    wdata:16'h0,    rdata:16'hBEEF, err:0, lat:3, writes:0};
    vecs[7]  = '{dm:0, we:0, addr:16'hFFFF, wdata:16'h0,    rdata:16'h0,    err:1, lat:1, writes:0};
    vecs[8]  = '{dm:1, we:1, addr:16'd256,  wdata:16'h1234, rdata:16'h0,    err:0, lat:2, writes:1};
    vecs[9]  = '{dm:0, we:0, addr:16'd256,  wdata:16'h0,    rdata:16'h1234, err:0, lat:3, writes:0};
    vecs[10] = '{dm:1, we:0, addr:16'd0,    wdata:16'h0,    rdata:16'd1,    err:0, lat:3, writes:0};

    // Reset state
    @(posedge clock); #1 load = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy0, 0);
    chk("rst_acks", {b0.if_ack, b0.dm_ack, b0.if_err, b0.dm_err}, 0);
    chk("rst_rdata", {b0.if_rdata, b0.dm_rdata}, 0);
    chk("rst_mem", {b0.mem_write, b0.mem_addr, b0.mem_wdata}, 0);
    @(posedge clock); #1 reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      xact0(vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat, nwr, oth);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_err", i), er, vecs[i].err);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_memwrites", i), nwr, vecs[i].writes);
      chk($sformatf("vec%0d_loser_ack", i), oth, 0);
    end
    chk("oor_write_mem_unchanged", mem0[300], 16'h04B1);

    // Reset during RDWAIT of a fetch aborts it
    @(posedge clock); #1 b0.if_req = 1'b1; b0.if_addr = 16'd2;
    @(posedge clock); @(posedge clock); #1;
    chk("abort_busy_before", busy0, 1);
    reset = 1'b1;
    @(posedge clock); #1 b0.if_req = 1'b0;
    @(negedge clock);
    chk("abort_busy", busy0, 0);
    chk("abort_mem_write", b0.mem_write, 0);
    chk("abort_if_ack", b0.if_ack, 0);
    @(posedge clock); #1 reset = 1'b0;
    n = 0;
    repeat (6) begin @(negedge clock); if (b0.if_ack) n++; end
    chk("abort_no_late_ack", n, 0);

    // Round-robin with both ports held: DM first after reset, then alternating
    @(posedge clock); #1;
    b0.if_req = 1'b1; b0.if_addr = 16'd3;
    b0.dm_req = 1'b1; b0.dm_we = 1'b0; b0.dm_addr = 16'd5;
    n = 0;
    for (int k = 0; k < 80 && n < 6; k++) begin
      @(negedge clock);
      if (b0.dm_ack) begin
        chk("rr_dm_rdata", b0.dm_rdata, 16'd21);
        order[n] = 1; n++;
      end else if (b0.if_ack) begin
        chk("rr_if_rdata", b0.if_rdata, 16'd13);
        order[n] = 0; n++;
      end
    end
    @(posedge clock); #1 b0.if_req = 1'b0; b0.dm_req = 1'b0;
    chk("rr_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), order[i], (i % 2 == 0) ? 1 : 0);

    // Random traffic against shadow memory
    for (int i = 0; i < 512; i++) shadow[i] = mem0[i];
    repeat (2) @(posedge clock); #1;
    fork
      rnd_port(1'b0);
      rnd_port(1'b1);
    join

    // Fixed priority: DM wins every conflict, IF served only once DM drops
    @(posedge clock); #1;
    b1.if_req = 1'b1; b1.if_addr = 16'd3;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 16'd5;
    n = 0; nif = 0; ndm_at_if = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (b1.if_ack) begin
        nif++; ndm_at_if = n;
        chk("fp_if_rdata", b1.if_rdata, 16'd13);
        break;
      end
      if (b1.dm_ack) begin
        n++;
        if (n == 4) begin @(posedge clock); #1 b1.dm_req = 1'b0; end
      end
    end
    @(posedge clock); #1 b1.if_req = 1'b0; b1.dm_req = 1'b0;
    chk("fp_dm_grants", n, 4);
    chk("fp_if_served", nif, 1);
    chk("fp_if_after_dm", ndm_at_if, 4);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
